// File: rtl/backward_registered_pkg.sv
// Shared state encodings and handshake helpers for the backward-registered slice.
package backward_registered_pkg;

  typedef enum logic [2:0] {
    ST_PASS  = 3'd0,
    ST_SKID  = 3'd1,
    ST_EMPTY = 3'd2,
    ST_ONE   = 3'd3,
    ST_TWO   = 3'd4
  } state_e;

  function automatic logic hs_fire(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

  // The skid register is occupied exactly in these states; upstream must be held off.
  function automatic logic is_skid_state(input state_e st);
    return (st == ST_SKID) || (st == ST_TWO);
  endfunction

endpackage

// File: rtl/backward_registered_if.sv
// Valid/ready bus around the slice: upstream side, downstream side and skid status.
interface backward_registered_if #(
  parameter int WIDTH = 8
);
  logic             src_vaild;
  logic [WIDTH-1:0] src_data_in;
  logic             src_ready;
  logic             dst_ready;
  logic             dst_vaild;
  logic [WIDTH-1:0] dst_data_out;
  logic             skid_full;

  modport master (
    output src_vaild, src_data_in, dst_ready,
    input  src_ready, dst_vaild, dst_data_out, skid_full
  );

  modport slave (
    input  src_vaild, src_data_in, dst_ready,
    output src_ready, dst_vaild, dst_data_out, skid_full
  );
endinterface

// File: rtl/backward_registered.sv
// Valid/ready slice with flop-driven src_ready and a one-entry skid; REG_FWD=1 also registers valid/data.
// Latency 0 (REG_FWD=0) or 1 (REG_FWD=1); a downstream stall is absorbed by the skid, then src_ready drops.
module backward_registered
  import backward_registered_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit REG_FWD = 1'b0
) (
  input  logic                 clk,
  input  logic                 s_rst_n,
  backward_registered_if.slave bus
);

  localparam state_e ST_RST = state_e'(REG_FWD ? ST_EMPTY : ST_PASS);

  state_e           state_q, state_d;
  logic             src_ready_q, src_ready_d;
  logic             skid_full_q, skid_full_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             dst_vld;
  logic [WIDTH-1:0] dst_dat;
  logic             accept;

  // src_ready_q is the only ready seen upstream, so a beat counts as accepted only against it.
  assign accept      = hs_fire(bus.src_vaild, src_ready_q);
  assign skid_full_d = is_skid_state(state_d);
  assign src_ready_d = !skid_full_d;

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= ST_RST;
      src_ready_q <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_ready_q <= src_ready_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
    end
  end

  if (!REG_FWD) begin : gen_fwd_comb
    always_comb begin
      state_d = state_q;
      skid_d  = skid_q;
      dst_vld = 1'b0;
      dst_dat = '0;
      case (state_q)
        ST_PASS: begin
          // Gating with src_ready_q keeps the cycle after reset release quiet.
          dst_vld = bus.src_vaild & src_ready_q;
          dst_dat = src_ready_q ? bus.src_data_in : '0;
          if (accept && !bus.dst_ready) begin
            skid_d  = bus.src_data_in;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          dst_vld = 1'b1;
          dst_dat = skid_q;
          if (bus.dst_ready) begin
            state_d = ST_PASS;
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end else begin : gen_fwd_reg
    logic [WIDTH-1:0] out_q, out_d;
    logic             consume;

    always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    always_comb begin
      state_d = state_q;
      skid_d  = skid_q;
      out_d   = out_q;
      dst_vld = 1'b0;
      consume = 1'b0;
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_d   = bus.src_data_in;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          dst_vld = 1'b1;
          consume = bus.dst_ready;
          if (accept && consume) begin
            out_d = bus.src_data_in;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            skid_d  = bus.src_data_in;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          dst_vld = 1'b1;
          consume = bus.dst_ready;
          if (consume) begin
            out_d   = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    assign dst_dat = out_q;
  end

  assign bus.src_ready    = src_ready_q;
  assign bus.skid_full    = skid_full_q;
  assign bus.dst_vaild    = dst_vld;
  assign bus.dst_data_out = dst_dat;

endmodule

// File: tb/tb_backward_registered.sv
// Bench for backward_registered: both REG_FWD variants side by side, vector tables,
// hand-written corner sequences and a random run against an occupancy/queue model.
module tb_backward_registered;

  localparam int W = 8;

  logic clk = 1'b0;
  logic s_rst_n;
  always #5 clk = ~clk;

  backward_registered_if #(.WIDTH(W)) bus0 ();
  backward_registered_if #(.WIDTH(W)) bus1 ();

  backward_registered #(.WIDTH(W), .REG_FWD(1'b0)) u_dut0 (
    .clk(clk), .s_rst_n(s_rst_n), .bus(bus0.slave)
  );
  backward_registered #(.WIDTH(W), .REG_FWD(1'b1)) u_dut1 (
    .clk(clk), .s_rst_n(s_rst_n), .bus(bus1.slave)
  );

  typedef struct {
    logic         sv;
    logic [W-1:0] sd;
    logic         dr;
    logic         ev;
    logic [W-1:0] ed;
    logic         er;
    logic         ef;
  } vec_t;

  vec_t vec0[8];
  vec_t vec1[8];

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  function automatic vec_t mk(input logic sv, input logic [W-1:0] sd, input logic dr,
                              input logic ev, input logic [W-1:0] ed, input logic er,
                              input logic ef);
    vec_t v;
    v.sv = sv; v.sd = sd; v.dr = dr; v.ev = ev; v.ed = ed; v.er = er; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int mode, input logic sv, input logic [W-1:0] sd, input logic dr);
    if (mode == 0) begin
      bus0.src_vaild = sv; bus0.src_data_in = sd; bus0.dst_ready = dr;
    end else begin
      bus1.src_vaild = sv; bus1.src_data_in = sd; bus1.dst_ready = dr;
    end
  endtask

  task automatic check_out(input string tag, input int mode, input logic ev,
                           input logic [W-1:0] ed, input logic er, input logic ef);
    logic av, ar, af;
    logic [W-1:0] ad;
    if (mode == 0) begin
      av = bus0.dst_vaild; ad = bus0.dst_data_out; ar = bus0.src_ready; af = bus0.skid_full;
    end else begin
      av = bus1.dst_vaild; ad = bus1.dst_data_out; ar = bus1.src_ready; af = bus1.skid_full;
    end
    chk($sformatf("%s.m%0d.dst_vaild", tag, mode), 32'(av), 32'(ev));
    if (ev) chk($sformatf("%s.m%0d.dst_data", tag, mode), 32'(ad), 32'(ed));
    chk($sformatf("%s.m%0d.src_ready", tag, mode), 32'(ar), 32'(er));
    chk($sformatf("%s.m%0d.skid_full", tag, mode), 32'(af), 32'(ef));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".m0.src_ready"}, 32'(bus0.src_ready), 0);
    chk({tag, ".m0.dst_vaild"}, 32'(bus0.dst_vaild), 0);
    chk({tag, ".m0.dst_data"},  32'(bus0.dst_data_out), 0);
    chk({tag, ".m0.skid_full"}, 32'(bus0.skid_full), 0);
    chk({tag, ".m1.src_ready"}, 32'(bus1.src_ready), 0);
    chk({tag, ".m1.dst_vaild"}, 32'(bus1.dst_vaild), 0);
    chk({tag, ".m1.dst_data"},  32'(bus1.dst_data_out), 0);
    chk({tag, ".m1.skid_full"}, 32'(bus1.skid_full), 0);
  endtask

  initial begin
    logic         sv0, sv1, dr0, dr1, ev0, ev1, er0, er1, ef0, ef1;
    logic [W-1:0] sd0, sd1, ed0, ed1;
    int           del0, del1, cyc;

    // Stall tables: {src_vaild, src_data, dst_ready} -> {dst_vaild, dst_data, src_ready, skid_full}
    vec0[0] = mk(1, 8'hA5, 0,  1, 8'hA5, 1, 0);
    vec0[1] = mk(1, 8'h5A, 0,  1, 8'hA5, 0, 1);
    vec0[2] = mk(1, 8'h5A, 0,  1, 8'hA5, 0, 1);
    vec0[3] = mk(1, 8'h5A, 1,  1, 8'hA5, 0, 1);
    vec0[4] = mk(1, 8'h5A, 1,  1, 8'h5A, 1, 0);
    vec0[5] = mk(0, 8'h00, 1,  0, 8'h00, 1, 0);
    vec0[6] = mk(1, 8'h3C, 1,  1, 8'h3C, 1, 0);
    vec0[7] = mk(0, 8'h00, 0,  0, 8'h00, 1, 0);

    vec1[0] = mk(1, 8'hA5, 0,  0, 8'h00, 1, 0);
    vec1[1] = mk(1, 8'h5A, 0,  1, 8'hA5, 1, 0);
    vec1[2] = mk(1, 8'h77, 0,  1, 8'hA5, 0, 1);
    vec1[3] = mk(1, 8'h77, 1,  1, 8'hA5, 0, 1);
    vec1[4] = mk(0, 8'h77, 0,  1, 8'h5A, 1, 0);
    vec1[5] = mk(1, 8'h66, 1,  1, 8'h5A, 1, 0);
    vec1[6] = mk(0, 8'h00, 1,  1, 8'h66, 1, 0);
    vec1[7] = mk(0, 8'h00, 0,  0, 8'h00, 1, 0);

    s_rst_n = 1'b0;
    drive(0, 0, '0, 0);
    drive(1, 0, '0, 0);
    #2;
    check_reset("reset_init");

    @(negedge clk);
    @(negedge clk);
    s_rst_n = 1'b1;
    #1;
    chk("release.m0.src_ready_low", 32'(bus0.src_ready), 0);
    chk("release.m1.src_ready_low", 32'(bus1.src_ready), 0);
    @(negedge clk);
    #1;
    chk("release.m0.src_ready_rise", 32'(bus0.src_ready), 1);
    chk("release.m1.src_ready_rise", 32'(bus1.src_ready), 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, vec0[i].sv, vec0[i].sd, vec0[i].dr);
      drive(1, vec1[i].sv, vec1[i].sd, vec1[i].dr);
      #1;
      check_out($sformatf("stall[%0d]", i), 0, vec0[i].ev, vec0[i].ed, vec0[i].er, vec0[i].ef);
      check_out($sformatf("stall[%0d]", i), 1, vec1[i].ev, vec1[i].ed, vec1[i].er, vec1[i].ef);
    end

    // Back-to-back 0x01..0x10 with the sink always ready.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(0, i < 16, 8'(i + 1), 1);
      drive(1, i < 16, 8'(i + 1), 1);
      #1;
      check_out($sformatf("stream[%0d]", i), 0, i < 16, 8'(i + 1), 1, 0);
      check_out($sformatf("stream[%0d]", i), 1, (i >= 1) && (i <= 16), 8'(i), 1, 0);
    end

    // Fill both variants, then reset while they hold beats.
    @(negedge clk);
    drive(0, 1, 8'h11, 0);
    drive(1, 1, 8'h11, 0);
    @(negedge clk);
    drive(0, 1, 8'h22, 0);
    drive(1, 1, 8'h22, 0);
    @(negedge clk);
    drive(0, 0, '0, 0);
    drive(1, 0, '0, 0);
    #1;
    check_out("hold", 0, 1, 8'h11, 0, 1);
    check_out("hold", 1, 1, 8'h11, 0, 1);
    #2;
    s_rst_n = 1'b0;
    #1;
    check_reset("reset_mid");
    @(negedge clk);
    s_rst_n = 1'b1;
    #1;
    chk("rerelease.m0.src_ready_low", 32'(bus0.src_ready), 0);
    chk("rerelease.m1.src_ready_low", 32'(bus1.src_ready), 0);
    @(negedge clk);
    drive(0, 1, 8'h33, 1);
    drive(1, 1, 8'h33, 1);
    #1;
    check_out("after_rst0", 0, 1, 8'h33, 1, 0);
    check_out("after_rst0", 1, 0, 8'h00, 1, 0);
    @(negedge clk);
    drive(0, 0, '0, 1);
    drive(1, 0, '0, 1);
    #1;
    check_out("after_rst1", 0, 0, 8'h00, 1, 0);
    check_out("after_rst1", 1, 1, 8'h33, 1, 0);
    @(negedge clk);
    #1;
    check_out("after_rst2", 1, 0, 8'h00, 1, 0);

    // Random traffic against a queue model: occupancy sets ready/full, queue head is the output.
    del0 = 0; del1 = 0; cyc = 0;
    while ((del0 < 10000 || del1 < 10000) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      sv0 = ($urandom_range(0, 3) != 0); sd0 = 8'($urandom); dr0 = ($urandom_range(0, 3) != 0);
      sv1 = ($urandom_range(0, 3) != 0); sd1 = 8'($urandom); dr1 = ($urandom_range(0, 3) != 0);
      drive(0, sv0, sd0, dr0);
      drive(1, sv1, sd1, dr1);
      #1;

      er0 = (q0.size() == 0);
      ef0 = (q0.size() != 0);
      if (q0.size() != 0) begin ev0 = 1'b1; ed0 = q0[0]; end
      else begin ev0 = sv0; ed0 = sd0; end
      check_out("rand", 0, ev0, ed0, er0, ef0);

      ev1 = (q1.size() != 0);
      ed1 = (q1.size() != 0) ? q1[0] : '0;
      er1 = (q1.size() < 2);
      ef1 = (q1.size() == 2);
      check_out("rand", 1, ev1, ed1, er1, ef1);

      if (sv0 && er0) q0.push_back(sd0);
      if (ev0 && dr0) begin void'(q0.pop_front()); del0++; end
      if (sv1 && er1) q1.push_back(sd1);
      if (ev1 && dr1) begin void'(q1.pop_front()); del1++; end
    end
    chk("rand.m0.beats_delivered", 32'(del0 >= 10000), 1);
    chk("rand.m1.beats_delivered", 32'(del1 >= 10000), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
